// File: rtl/debounce_pkg.sv
// debounce_pkg
// Shared definitions for the pushbutton debouncer slice.
//   chanState_t : per-channel filter FSM states (STABLE / WAIT)
//   cntWidth    : width of the stability counter for a given STABLE_CYCLES
//   hcntWidth   : width of the hold counter for a given LONG_CYCLES
package debounce_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    WAIT   = 1'b1
  } chanState_t;

  // The stability counter only has to reach STABLE_CYCLES-1, because the
  // commit happens on the edge that sees that value.  The width is forced
  // to at least one bit so a degenerate setting still elaborates.
  function automatic int cntWidth(input int stableCycles);
    if (stableCycles < 2) begin
      return 1;
    end
    return $clog2(stableCycles);
  endfunction

  // The hold counter saturates at LONG_CYCLES, so it must be able to hold
  // that value.  With the long-press feature disabled the counter is never
  // built, but a one-bit width keeps any declaration legal.
  function automatic int hcntWidth(input int longCycles);
    if (longCycles < 1) begin
      return 1;
    end
    return $clog2(longCycles + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan
// One pushbutton channel: polarity fix-up, synchroniser chain, stability
// filter FSM, edge pulses and an optional long-press detector.
// Ports:
//   clk        in  system clock, rising edge
//   rst_n      in  synchronous active-low reset
//   din        in  raw asynchronous button input
//   level      out debounced level (registered)
//   rise       out one-cycle pulse on an accepted 0->1 change of level
//   fall       out one-cycle pulse on an accepted 1->0 change of level
//   long_press out one-cycle pulse once level has been high LONG_CYCLES cycles
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 50000,
  parameter int LONG_CYCLES   = 0,
  parameter bit INVERT        = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam int CNT_W = cntWidth(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_x;
  logic                   w_s;

  chanState_t             r_state;
  chanState_t             w_nextState;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_nextCnt;

  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_commit;
  logic                   w_levelNext;
  logic                   w_riseNext;
  logic                   w_fallNext;

  // Active-low buttons are flipped before the synchroniser so that everything
  // downstream works in logical polarity, where 1 always means pressed.
  assign w_x = din ^ INVERT;
  assign w_s = r_sync[SYNC_STAGES-1];

  // Synchroniser chain.  Reset clears it to the logical idle value so a
  // channel never sees a phantom press coming out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_x};
    end
  end

  // Filter FSM state register together with its stability counter.  Reset
  // takes priority, so a WAIT that was about to commit is simply dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= STABLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  // Next-state logic.  Any disagreement between the synchronised sample and
  // the published level starts a WAIT run; a single agreeing sample during
  // that run is treated as a glitch and abandons it.  The counter cannot
  // pass CNT_LAST because reaching it always ends the run.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    case (r_state)
      STABLE: begin
        if (w_s != r_level) begin
          w_nextState = WAIT;
          w_nextCnt   = CNT_ONE;
        end else begin
          w_nextCnt   = '0;
        end
      end
      WAIT: begin
        if (w_s == r_level) begin
          w_nextState = STABLE;
          w_nextCnt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_nextState = STABLE;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_nextState = STABLE;
        w_nextCnt   = '0;
      end
    endcase
  end

  // Output decode.  A commit flips the level and picks which edge pulse to
  // raise from the level being left behind.
  always_comb begin
    w_commit    = (r_state == WAIT) && (w_s != r_level) && (r_cnt == CNT_LAST);
    w_levelNext = w_commit ? ~r_level : r_level;
    w_riseNext  = w_commit && !r_level;
    w_fallNext  = w_commit && r_level;
  end

  // Output registers, so consumers never see a combinational path from the
  // pins.  The pulses are recomputed every cycle and so last exactly one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_level <= w_levelNext;
      r_rise  <= w_riseNext;
      r_fall  <= w_fallNext;
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

  generate
    if (LONG_CYCLES > 0) begin : g_long
      localparam int HCNT_W = hcntWidth(LONG_CYCLES);
      localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(LONG_CYCLES - 1);
      localparam logic [HCNT_W-1:0] HCNT_MAX  = HCNT_W'(LONG_CYCLES);
      localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);

      logic [HCNT_W-1:0] r_hcnt;
      logic              r_longPress;

      // Hold counter follows the debounced level rather than the raw sample,
      // so bounce during release cannot restart it.  It is cleared while the
      // level is low and on any commit edge, and it parks at HCNT_MAX so that
      // one press yields at most one long-press pulse.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_hcnt <= '0;
        end else if (!r_level || w_commit) begin
          r_hcnt <= '0;
        end else if (r_hcnt != HCNT_MAX) begin
          r_hcnt <= r_hcnt + HCNT_ONE;
        end
      end

      // The pulse is raised on the edge that moves the counter from
      // HCNT_LAST into saturation, which is LONG_CYCLES edges after the
      // commit that raised the level.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_longPress <= 1'b0;
        end else begin
          r_longPress <= r_level && !w_commit && (r_hcnt == HCNT_LAST);
        end
      end

      assign long_press = r_longPress;
    end else begin : g_noLong
      assign long_press = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/debounce_sync_n.sv
// debounce_sync_n
// Multi-channel pushbutton conditioner feeding the PWM control logic.  Each
// channel is an independent debounce_chan; they share only clock and reset.
// Ports:
//   clk        in  system clock, rising edge
//   rst_n      in  synchronous active-low reset
//   din        in  [CHANNELS] raw asynchronous button inputs
//   level      out [CHANNELS] debounced levels
//   rise       out [CHANNELS] one-cycle rising-edge pulses
//   fall       out [CHANNELS] one-cycle falling-edge pulses
//   long_press out [CHANNELS] one-cycle long-press pulses (0 when disabled)
module debounce_sync_n
  import debounce_pkg::*;
#(
  parameter int                  CHANNELS      = 4,
  parameter int                  SYNC_STAGES   = 2,
  parameter int                  STABLE_CYCLES = 50000,
  parameter int                  LONG_CYCLES   = 0,
  parameter logic [CHANNELS-1:0] INVERT        = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] long_press
);

  // One filter per button.  Each instance receives its own polarity bit so
  // active-low and active-high buttons can be mixed on the same block.
  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      debounce_chan #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .LONG_CYCLES  (LONG_CYCLES),
        .INVERT       (INVERT[i])
      ) u_chan (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din[i]),
        .level     (level[i]),
        .rise      (rise[i]),
        .fall      (fall[i]),
        .long_press(long_press[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_debounce_sync_n.sv
// tb_debounce_sync_n
// Directed bench for debounce_sync_n with two channels, channel 1 active-low,
// a four-sample stability window and a ten-cycle long press.
module tb_debounce_sync_n;

  localparam int         CHANNELS      = 2;
  localparam int         SYNC_STAGES   = 2;
  localparam int         STABLE_CYCLES = 4;
  localparam int         LONG_CYCLES   = 10;
  localparam logic [1:0] INVERT        = 2'b10;

  logic       clock = 1'b0;
  logic       resetN;
  logic [1:0] din;
  logic [1:0] level;
  logic [1:0] rise;
  logic [1:0] fall;
  logic [1:0] longPress;

  int testCount = 0;
  int failCount = 0;

  // 10-time-unit clock; rising edges at 5, 15, 25, ...
  always #5 clock = ~clock;

  debounce_sync_n #(
    .CHANNELS     (CHANNELS),
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .LONG_CYCLES  (LONG_CYCLES),
    .INVERT       (INVERT)
  ) u_dut (
    .clk       (clock),
    .rst_n     (resetN),
    .din       (din),
    .level     (level),
    .rise      (rise),
    .fall      (fall),
    .long_press(longPress)
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges and settle just past the last one, so inputs set
  // afterwards are first sampled on the following edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic rstNVal, input logic [1:0] dinVal);
    resetN = rstNVal;
    din    = dinVal;
  endtask

  // Idle inputs: channel 0 released (0), channel 1 released (1, active-low).
  task automatic doReset();
    applyStimulus(1'b0, 2'b10);
    tick(2);
    applyStimulus(1'b1, 2'b10);
  endtask

  // Directed scenarios; edge numbers in comments count from the first edge
  // that samples the new input value.
  initial begin
    int n;
    logic [4:0] bouncePat;
    logic seenLevel, seenRise, seenFall, seenLong;

    doReset();
    checkOutput("reset_outputs", {level, rise, fall, longPress}, 8'h00);
    tick(3);
    checkOutput("idle_levels", level, 2'b00);

    // Clean press on channel 0, held long enough for the long press.
    applyStimulus(1'b1, 2'b11);
    tick(5);
    checkOutput("press_e5_level", level, 2'b00);
    tick(1);
    checkOutput("press_e6_level", level, 2'b01);
    checkOutput("press_e6_rise", rise, 2'b01);
    checkOutput("press_e6_fall", fall, 2'b00);
    tick(1);
    checkOutput("press_e7_rise", rise, 2'b00);
    checkOutput("press_e7_level", level, 2'b01);
    tick(8);
    checkOutput("long_e15", longPress, 2'b00);
    tick(1);
    checkOutput("long_e16", longPress, 2'b01);
    tick(1);
    checkOutput("long_e17", longPress, 2'b00);
    n = 0;
    repeat (20) begin
      tick(1);
      if (longPress != 2'b00) n++;
    end
    checkOutput("long_no_repeat", n, 0);
    checkOutput("hcnt_saturated", u_dut.g_chan[0].u_chan.g_long.r_hcnt, 10);

    // Release with bounce: 0,1,0 then held at 0; final settle at A3.
    applyStimulus(1'b1, 2'b10);
    tick(1);
    applyStimulus(1'b1, 2'b11);
    tick(1);
    applyStimulus(1'b1, 2'b10);
    tick(1);
    n = 0;
    repeat (4) begin
      tick(1);
      if (fall[0]) n++;
    end
    checkOutput("release_a7_level", level, 2'b01);
    checkOutput("release_no_early_fall", n, 0);
    tick(1);
    checkOutput("release_a8_fall", fall, 2'b01);
    checkOutput("release_a8_level", level, 2'b00);
    tick(1);
    checkOutput("release_a9_fall", fall, 2'b00);
    checkOutput("hcnt_cleared", u_dut.g_chan[0].u_chan.g_long.r_hcnt, 0);

    // Bounce on press: high 2, low 1, high 2, then low; never long enough.
    bouncePat = 5'b11011;
    seenLevel = 1'b0;
    seenRise  = 1'b0;
    seenFall  = 1'b0;
    seenLong  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, {1'b1, bouncePat[i]});
      tick(1);
      seenLevel |= level[0];
      seenRise  |= rise[0];
      seenFall  |= fall[0];
      seenLong  |= longPress[0];
    end
    applyStimulus(1'b1, 2'b10);
    repeat (10) begin
      tick(1);
      seenLevel |= level[0];
      seenRise  |= rise[0];
      seenFall  |= fall[0];
      seenLong  |= longPress[0];
    end
    checkOutput("bounce_level", seenLevel, 1'b0);
    checkOutput("bounce_rise", seenRise, 1'b0);
    checkOutput("bounce_fall", seenFall, 1'b0);
    checkOutput("bounce_long", seenLong, 1'b0);

    // Simultaneous press: channel 0 high, channel 1 pulled low (inverted).
    applyStimulus(1'b1, 2'b01);
    tick(5);
    checkOutput("dual_e5_level", level, 2'b00);
    tick(1);
    checkOutput("dual_e6_level", level, 2'b11);
    checkOutput("dual_e6_rise", rise, 2'b11);
    tick(1);
    checkOutput("dual_e7_rise", rise, 2'b00);

    // Reset in the middle of a WAIT run on channel 0.
    doReset();
    checkOutput("rst2_outputs", {level, rise, fall, longPress}, 8'h00);
    applyStimulus(1'b1, 2'b11);
    tick(3);
    checkOutput("rst2_cnt_e3", u_dut.g_chan[0].u_chan.r_cnt, 1);
    applyStimulus(1'b0, 2'b11);
    tick(1);
    checkOutput("rst2_e4_outputs", {level, rise, fall, longPress}, 8'h00);
    applyStimulus(1'b1, 2'b11);
    tick(1);
    checkOutput("rst2_e5_outputs", {level, rise, fall, longPress}, 8'h00);
    tick(4);
    checkOutput("rst2_e9_level", level, 2'b00);
    tick(1);
    checkOutput("rst2_e10_level", level, 2'b01);
    checkOutput("rst2_e10_rise", rise, 2'b01);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
